mmio_arbiter: RTL and testbench

MMIO_ARBITER -- requirements
Module: mmio_arbiter

---
 rtl/mmio_arb_pkg.sv | 14 +
 rtl/mmio_arbiter_if.sv | 49 ++++
 rtl/mmio_arb_pick.sv | 29 ++
 rtl/mmio_arbiter.sv | 99 +++++++++
 tb/tb_mmio_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-master MMIO arbiter.
// Imported by the interface, the winner picker and the arbiter top.
package mmio_arb_pkg;

    localparam int DEFAULT_ADDR_W = 21;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : mmio_arb_pkg

// File: rtl/mmio_arbiter_if.sv
// Bus bundle between two MMIO masters, the arbiter and the MMIO controller.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mmio_arbiter_if #(
    parameter int ADDR_W = mmio_arb_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W = mmio_arb_pkg::DEFAULT_DATA_W
);
    // Handshake: a master raises req with wr/addr/wr_data stable and keeps it high
    // until its ack pulses for one cycle. An access latched by the arbiter always
    // completes (barring reset), and req still high after ack is a fresh request.
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;

    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;

    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wr_data,
        output m0_ack, m0_rd_data,
        input  m1_req, m1_wr, m1_addr, m1_wr_data,
        output m1_ack, m1_rd_data,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  mmio_rd_data
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wr_data,
        input  m0_ack, m0_rd_data,
        output m1_req, m1_wr, m1_addr, m1_wr_data,
        input  m1_ack, m1_rd_data,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output mmio_rd_data
    );

endinterface : mmio_arbiter_if

// File: rtl/mmio_arb_pick.sv
// Combinational winner selection between two requesters.
// MMIO_ARB_ROUND_ROBIN_EN: ties go to the master that did not win last; otherwise m0 wins ties.
module mmio_arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

`ifdef MMIO_ARB_ROUND_ROBIN_EN
    always_comb begin
        valid  = |req;
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_grant;
        end
    end
`else
    // Fixed priority keeps last_grant wired in so both builds share one port list.
    logic last_grant_unused;
    assign last_grant_unused = last_grant;

    always_comb begin
        valid  = |req;
        winner = req[1] & ~req[0];
    end
`endif

endmodule : mmio_arb_pick

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: IDLE latches a winner, ISSUE strobes the bus for one cycle,
// DONE acks the winner. Optional MMIO_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    mmio_arbiter_if.slave  bus,
    output state_t         state_dbg,
    output logic           last_grant_dbg
);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        req;
    logic              pick_id;
    logic              pick_valid;
    logic              last_grant_q;
    logic              lat_wr;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] rd_cap;
    logic [DATA_W-1:0] m0_rd_q;
    logic [DATA_W-1:0] m1_rd_q;
    logic              issue;
    logic              done_ack;

    assign req = {bus.m1_req, bus.m0_req};

    mmio_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_wr       <= 1'b0;
            lat_id       <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            rd_cap       <= '0;
            m0_rd_q      <= '0;
            m1_rd_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                lat_id       <= pick_id;
                last_grant_q <= pick_id;
                lat_wr       <= pick_id ? bus.m1_wr      : bus.m0_wr;
                lat_addr     <= pick_id ? bus.m1_addr    : bus.m0_addr;
                lat_data     <= pick_id ? bus.m1_wr_data : bus.m0_wr_data;
            end
            if (state_q == ISSUE && !lat_wr) begin
                rd_cap <= bus.mmio_rd_data;
            end
            // Read data lands at the end of DONE so a reset during DONE leaves it untouched.
            if (state_q == DONE && !lat_wr) begin
                if (lat_id) m1_rd_q <= rd_cap;
                else        m0_rd_q <= rd_cap;
            end
        end
    end

    assign issue             = (state_q == ISSUE);
    assign bus.mmio_cs       = issue;
    assign bus.mmio_wr       = issue & lat_wr;
    assign bus.mmio_rd       = issue & ~lat_wr;
    assign bus.mmio_addr     = issue ? lat_addr : '0;
    assign bus.mmio_wr_data  = issue ? lat_data : '0;

    // A reset arriving while in DONE suppresses the ack of the aborted access.
    assign done_ack          = (state_q == DONE) & ~reset;
    assign bus.m0_ack        = done_ack & ~lat_id;
    assign bus.m1_ack        = done_ack & lat_id;
    assign bus.m0_rd_data    = m0_rd_q;
    assign bus.m1_rd_data    = m1_rd_q;

    assign state_dbg         = state_q;
    assign last_grant_dbg    = last_grant_q;

endmodule : mmio_arbiter

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios then randomized traffic
// against a transaction-level reference model.
module tb_mmio_arbiter;
    import mmio_arb_pkg::*;

    localparam int AW = DEFAULT_ADDR_W;
    localparam int DW = DEFAULT_DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    state_t state_dbg;
    logic   last_grant_dbg;

    mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .state_dbg      (state_dbg),
        .last_grant_dbg (last_grant_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding transaction, described by the cycle it was accepted in:
    // bus strobe one cycle later, ack two cycles later.
    logic          exp_q[$];
    bit            act = 0;
    int            t_start = 0;
    bit            t_id = 0;
    bit            t_wr = 0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_data = '0;
    logic [DW-1:0] t_rd = '0;
    logic [DW-1:0] rd_exp [2] = '{default: '0};
    bit            lg = 1'b1;
    bit            saw_ack [2] = '{default: 1'b0};

    function automatic bit model_pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef MMIO_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic tick();
        bit e_iss;
        bit e_ack;
        bit w;
        logic [63:0] e_state;
        @(negedge clk);
        e_iss = act && (cyc == t_start + 1);
        e_ack = act && (cyc == t_start + 2) && !reset;
        e_state = !act ? 64'(IDLE) : (e_iss ? 64'(ISSUE) : 64'(DONE));
        check("mmio_cs",      64'(bus.mmio_cs),      64'(e_iss));
        check("mmio_wr",      64'(bus.mmio_wr),      64'(e_iss && t_wr));
        check("mmio_rd",      64'(bus.mmio_rd),      64'(e_iss && !t_wr));
        check("mmio_addr",    64'(bus.mmio_addr),    e_iss ? 64'(t_addr) : 64'(0));
        check("mmio_wr_data", 64'(bus.mmio_wr_data), e_iss ? 64'(t_data) : 64'(0));
        check("m0_ack",       64'(bus.m0_ack),       64'(e_ack && !t_id));
        check("m1_ack",       64'(bus.m1_ack),       64'(e_ack && t_id));
        check("m0_rd_data",   64'(bus.m0_rd_data),   64'(rd_exp[0]));
        check("m1_rd_data",   64'(bus.m1_rd_data),   64'(rd_exp[1]));
        check("state",        64'(state_dbg),        e_state);
        check("last_grant",   64'(last_grant_dbg),   64'(lg));
        saw_ack[0] = bus.m0_ack;
        saw_ack[1] = bus.m1_ack;
        if (bus.m0_ack || bus.m1_ack) begin
            check("ack_queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("ack_order", 64'(bus.m1_ack), 64'(exp_q.pop_front()));
        end
        // advance the model to the next edge
        if (reset) begin
            act = 0;
            lg = 1'b1;
            rd_exp = '{default: '0};
            exp_q.delete();
        end else if (act) begin
            if (e_iss && !t_wr) t_rd = bus.mmio_rd_data;
            if (cyc == t_start + 2) begin
                if (!t_wr) rd_exp[t_id] = t_rd;
                act = 0;
            end
        end else if (bus.m0_req || bus.m1_req) begin
            w = model_pick(bus.m0_req, bus.m1_req, lg);
            act = 1;
            t_start = cyc;
            t_id = w;
            lg = w;
            t_wr   = w ? bus.m1_wr      : bus.m0_wr;
            t_addr = w ? bus.m1_addr    : bus.m0_addr;
            t_data = w ? bus.m1_wr_data : bus.m0_wr_data;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_m(input int i, input logic req, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (i == 0) begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wr_data = data;
        end else begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wr_data = data;
        end
    endtask

    task automatic drive_random();
        bit cur_req;
        for (int i = 0; i < 2; i++) begin
            cur_req = (i == 0) ? bus.m0_req : bus.m1_req;
            if (!cur_req || saw_ack[i]) begin
                if ($urandom_range(0, 3) != 0)
                    set_m(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                else
                    set_m(i, 1'b0, 1'b0, '0, '0);
            end else if ($urandom_range(0, 15) == 0) begin
                set_m(i, 1'b0, 1'b0, '0, '0);
            end
        end
        bus.mmio_rd_data = DW'($urandom);
        reset = ($urandom_range(0, 99) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_ack;
        logic ack_id [4];
        int ack_cyc [4];

        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        bus.mmio_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // single read by m0
        set_m(0, 1'b1, 1'b0, AW'(32'h00020), '0);
        bus.mmio_rd_data = 32'hDEADBEEF;
        tick();
        check("rd_cs",     64'(bus.mmio_cs), 64'(1));
        check("rd_strobe", 64'(bus.mmio_rd), 64'(1));
        tick();
        check("rd_ack",    64'(bus.m0_ack),  64'(1));
        set_m(0, 1'b0, 1'b0, '0, '0);
        tick();
        check("rd_value",  64'(bus.m0_rd_data), 64'(32'hDEADBEEF));

        // single write by m1
        set_m(1, 1'b1, 1'b1, AW'(32'h00041), 32'h12345678);
        tick();
        check("wr_strobe", 64'(bus.mmio_wr), 64'(1));
        check("wr_addr",   64'(bus.mmio_addr), 64'(32'h00041));
        check("wr_data",   64'(bus.mmio_wr_data), 64'(32'h12345678));
        tick();
        check("wr_strobe_off", 64'(bus.mmio_wr), 64'(0));
        check("wr_ack",    64'(bus.m1_ack), 64'(1));
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();
        check("wr_keeps_rd", 64'(bus.m1_rd_data), 64'(0));

        // contention, last_grant is m1 at this point
        set_m(0, 1'b1, 1'b0, AW'(32'h00100), '0);
        set_m(1, 1'b1, 1'b0, AW'(32'h00200), '0);
        bus.mmio_rd_data = 32'hA5A5_0001;
        n_ack = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if ((bus.m0_ack || bus.m1_ack) && n_ack < 4) begin
                ack_id[n_ack] = bus.m1_ack;
                ack_cyc[n_ack] = k;
                n_ack++;
            end
        end
        check("cont_ack_count", 64'(n_ack), 64'(4));
        for (int k = 0; k < n_ack; k++) begin
`ifdef MMIO_ARB_ROUND_ROBIN_EN
            check("cont_grant", 64'(ack_id[k]), 64'(k % 2));
`else
            check("cont_grant", 64'(ack_id[k]), 64'(0));
`endif
            check("cont_spacing", 64'(ack_cyc[k]), 64'(2 + 3 * k));
        end
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();

        // req dropped after latch still completes
        set_m(0, 1'b1, 1'b0, AW'(32'h00033), '0);
        bus.mmio_rd_data = 32'h0BAD_F00D;
        tick();
        set_m(0, 1'b0, 1'b0, '0, '0);
        tick();
        check("drop_ack", 64'(bus.m0_ack), 64'(1));
        tick();

        // reset during ISSUE aborts; next contested grant goes to m0
        set_m(0, 1'b1, 1'b1, AW'(32'h00077), 32'h5555AAAA);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_cs",    64'(bus.mmio_cs), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_noack", 64'(bus.m0_ack), 64'(0));
        set_m(1, 1'b1, 1'b0, AW'(32'h00088), '0);
        tick();
        tick();
        check("rst_regrant_m0", 64'(bus.m0_ack), 64'(1));
        check("rst_regrant_m1", 64'(bus.m1_ack), 64'(0));
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            tick();
        end

        // drain
        reset = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        repeat (5) tick();
        check("drain_queue", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mmio_arbiter
